// File: rtl/pipe_rca_adder_pkg.sv
// Shared defaults and elaboration helpers for the pipelined ripple-carry adder.
package pipe_rca_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Bits summed per pipeline stage.
  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  // Legal geometry: at least one stage, no more stages than bits, equal slices.
  function automatic logic params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_rca_adder_rca_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into its MSB
// so the last stage can form signed overflow.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  // Carry ripples from LSB to MSB one full-adder at a time.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder: one SLICE-bit chunk of a+b+cin per stage,
// carry registered between stages, valid/ready flow control with collapsing bubbles.
module pipe_rca_adder
  import pipe_rca_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipe_rca_adder: WIDTH must be a positive multiple of STAGES");
  end

  // Per-stage registers. Operands are kept right-aligned: each stage shifts out
  // the slice it consumed, so the next stage always works on bits [SLICE-1:0].
  logic             vld_p   [STAGES];
  logic             carry_p [STAGES];
  logic             cmsb_p  [STAGES];
  logic [WIDTH-1:0] sum_p   [STAGES];
  logic [WIDTH-1:0] a_rem_p [STAGES];
  logic [WIDTH-1:0] b_rem_p [STAGES];

  // Stage inputs (from ports for stage 0, from the previous stage otherwise).
  logic             v_in    [STAGES];
  logic             c_in    [STAGES];
  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic [WIDTH-1:0] sum_nx  [STAGES];

  // Slice results.
  logic [SLICE-1:0] sl_s    [STAGES];
  logic             sl_co   [STAGES];
  logic             sl_cm   [STAGES];

  // load_p[k]: stage k captures its input this cycle; load_p[STAGES] is the consumer.
  logic [STAGES:0]  load_p;

  // Route each stage's source: ports into stage 0, registered stage k-1 into stage k.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        v_in[k] = in_valid;
        c_in[k] = cin;
        a_in[k] = a;
        b_in[k] = b;
      end else begin
        v_in[k] = vld_p[k-1];
        c_in[k] = carry_p[k-1];
        a_in[k] = a_rem_p[k-1];
        b_in[k] = b_rem_p[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    rca_slice #(.W(SLICE)) u_slice (
      .a     (a_in[k][SLICE-1:0]),
      .b     (b_in[k][SLICE-1:0]),
      .cin   (c_in[k]),
      .s     (sl_s[k]),
      .cout  (sl_co[k]),
      .c_msb (sl_cm[k])
    );
  end

  // Merge each stage's fresh slice into the partial sum travelling with the item.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_nx[k] = (k == 0) ? '0 : sum_p[k-1];
      sum_nx[k][k*SLICE +: SLICE] = sl_s[k];
    end
  end

  // Load enables resolve from the output backwards so a full pipe can still
  // accept when the consumer drains; an empty stage always loads, collapsing bubbles.
  always_comb begin
    load_p         = '0;
    load_p[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load_p[k] = !vld_p[k] || load_p[k+1];
    end
  end

  // Stage valid bits: take the upstream valid whenever the stage loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_p[k]) vld_p[k] <= v_in[k];
      end
    end
  end

  // Stage data: only a real item is captured, so outputs hold their last
  // (or reset) value while no item is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        carry_p[k] <= 1'b0;
        cmsb_p[k]  <= 1'b0;
        sum_p[k]   <= '0;
        a_rem_p[k] <= '0;
        b_rem_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_p[k] && v_in[k]) begin
          carry_p[k] <= sl_co[k];
          cmsb_p[k]  <= sl_cm[k];
          sum_p[k]   <= sum_nx[k];
          a_rem_p[k] <= a_in[k] >> SLICE;
          b_rem_p[k] <= b_in[k] >> SLICE;
        end
      end
    end
  end

  assign in_ready  = load_p[0];
  assign out_valid = vld_p[STAGES-1];
  assign s         = sum_p[STAGES-1];
  assign cout      = carry_p[STAGES-1];
  assign ovf       = carry_p[STAGES-1] ^ cmsb_p[STAGES-1];

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed and randomized bench for pipe_rca_adder (WIDTH=16, STAGES=4).
module tb_pipe_rca_adder;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  // Pre-edge samples taken by tick().
  logic         acc;
  logic         emit;
  logic [W-1:0] es;
  logic         ec;
  logic         eo;

  always #5 clk = ~clk;

  pipe_rca_adder #(.WIDTH(W), .STAGES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {ovf, cout, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] full;
    full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    model = {(x[W-1] == y[W-1]) && (full[W-1] != x[W-1]), full};
  endfunction

  // Called 1ns after a rising edge with inputs already driven: records the
  // handshakes that the next edge will perform, then advances past that edge.
  task automatic tick();
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    es   = s;
    ec   = cout;
    eo   = ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({out_valid, s, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got ov=%b s=%h c=%b o=%b ir=%b want ov=0 s=0000 c=0 o=0 ir=1",
               out_valid, s, cout, ovf, in_ready);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] va [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF};
    logic [W-1:0] vb [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h4321, 16'hFFFF};
    logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] ve [5] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000},
                             {1'b1, 1'b1, 16'h0000}, {1'b0, 1'b0, 16'h5556},
                             {1'b0, 1'b1, 16'hFFFF}};
    int lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      total++;
      if (acc !== 1'b1) begin
        bad++;
        $display("FAIL single_accept[%0d]: got %b want 1", i, acc);
      end
      lat = 0;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      total++;
      if (lat != N - 1) begin
        bad++;
        $display("FAIL single_latency[%0d]: got %0d want %0d", i, lat, N - 1);
      end
      total++;
      if ({ovf, cout, s} !== ve[i]) begin
        bad++;
        $display("FAIL single_result[%0d]: got o=%b c=%b s=%h want o=%b c=%b s=%h",
                 i, ovf, cout, s, ve[i][W+1], ve[i][W], ve[i][W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] q[$];
    logic [W+1:0] want;
    int first = -1;
    int last  = -1;
    int n_em  = 0;
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      in_valid = (t < 8);
      a   = 16'(t * 16'h2222);
      b   = 16'h1111;
      cin = t[0];
      if (in_valid) q.push_back(model(a, b, cin));
      tick();
      if (t < 8) begin
        total++;
        if (acc !== 1'b1) begin
          bad++;
          $display("FAIL b2b_accept[%0d]: got %b want 1", t, acc);
        end
      end
      if (emit) begin
        if (first < 0) first = t;
        last = t;
        n_em++;
        want = (q.size() > 0) ? q.pop_front() : '1;
        total++;
        if ({eo, ec, es} !== want) begin
          bad++;
          $display("FAIL b2b_data[%0d]: got %h want %h", t, {eo, ec, es}, want);
        end
      end
    end
    total++;
    if (first != N || n_em != 8 || (last - first) != 7) begin
      bad++;
      $display("FAIL b2b_timing: got first=%0d count=%0d span=%0d want first=%0d count=8 span=7",
               first, n_em, last - first, N);
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] q[$];
    logic [W+1:0] want;
    int n_acc = 0;
    int n_em  = 0;
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1;
      a = 16'(16'h0100 * (t + 1)); b = 16'h00FF; cin = 1'b0;
      tick();
      if (acc) begin
        n_acc++;
        q.push_back(model(a, b, cin));
      end
      if (t >= 4) begin
        total++;
        if (es !== 16'h01FF || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL bp_hold[%0d]: got s=%h ov=%b want s=01ff ov=1", t, es, out_valid);
        end
      end
    end
    total++;
    if (n_acc != N) begin
      bad++;
      $display("FAIL bp_accepted: got %0d want %0d", n_acc, N);
    end
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_in_ready_release: got %b want 1", in_ready);
    end
    for (int t = 0; t < 14; t++) begin
      in_valid = (t < 4);
      a = 16'(16'hA000 + t); b = 16'(16'h7000 - t); cin = t[0];
      tick();
      if (acc) q.push_back(model(a, b, cin));
      if (emit) begin
        n_em++;
        want = (q.size() > 0) ? q.pop_front() : '1;
        total++;
        if ({eo, ec, es} !== want) begin
          bad++;
          $display("FAIL bp_drain[%0d]: got %h want %h", n_em, {eo, ec, es}, want);
        end
      end
    end
    total++;
    if (n_em != 8 || q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got emitted=%0d left=%0d want emitted=8 left=0", n_em, q.size());
    end
  endtask

  task automatic test_reset_flush();
    int n_em = 0;
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; a = 16'hCAFE; b = 16'(t); cin = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, s, in_ready} !== {1'b0, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL flush_state: got ov=%b s=%h ir=%b want ov=0 s=0000 ir=1",
               out_valid, s, in_ready);
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      if (emit) n_em++;
    end
    total++;
    if (n_em != 0) begin
      bad++;
      $display("FAIL flush_ghost: got %0d emitted want 0", n_em);
    end
  endtask

  task automatic test_random();
    logic [W+1:0] q[$];
    logic [W+1:0] want;
    int n_acc = 0;
    int n_em  = 0;
    int errs  = 0;
    do_reset();
    for (int t = 0; t < 1200; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      tick();
      if (acc) begin
        n_acc++;
        q.push_back(model(a, b, cin));
      end
      if (emit) begin
        n_em++;
        want = (q.size() > 0) ? q.pop_front() : '1;
        total++;
        if ({eo, ec, es} !== want) begin
          bad++;
          errs++;
          if (errs < 10) $display("FAIL rand_data[%0d]: got %h want %h", n_em, {eo, ec, es}, want);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (emit) begin
        n_em++;
        want = (q.size() > 0) ? q.pop_front() : '1;
        total++;
        if ({eo, ec, es} !== want) begin
          bad++;
          $display("FAIL rand_drain[%0d]: got %h want %h", n_em, {eo, ec, es}, want);
        end
      end
    end
    total++;
    if (n_em != n_acc || q.size() != 0 || n_acc < 500) begin
      bad++;
      $display("FAIL rand_count: got accepted=%0d emitted=%0d left=%0d want equal counts, none left",
               n_acc, n_em, q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
